// File: rtl/spi_cs_sequencer.sv
// SPI transaction sequencer: buffers TX words in a small FIFO, frames an
// N-word transaction with active-low chip select, hands words to the SPI
// master one at a time and returns each received word on a registered
// stream. CS setup, hold and inter-transaction idle times are programmable.
module spi_cs_sequencer #(
  parameter int MAX_WORDS     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int CS_IDLE_CLKS  = 8,
  parameter int WC_W          = $clog2(MAX_WORDS + 1)
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_Start,
  input  logic [WC_W-1:0] i_Word_Count,
  output logic            o_Busy,
  output logic            o_Done,
  input  logic [15:0]     i_Data,
  input  logic            i_Data_DV,
  output logic            o_FIFO_Full,
  output logic            o_Overflow,
  output logic [15:0]     o_RX_Word,
  output logic            o_RX_DV,
  output logic [15:0]     o_TX_Word,
  output logic            o_TX_DV,
  input  logic            i_TX_Ready,
  input  logic            i_RX_DV,
  input  logic [15:0]     i_RX_Word,
  output logic            o_SPI_CS_n
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int MAX_A    = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int MAX_CLKS = (MAX_A > CS_IDLE_CLKS) ? MAX_A : CS_IDLE_CLKS;
  localparam int CNT_W    = $clog2(MAX_CLKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_LOAD, ST_WAIT_RX, ST_HOLD, ST_GAP
  } state_t;

  // TX FIFO storage and bookkeeping
  logic [15:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   fifo_cnt_r, fifo_cnt_nx_s;
  logic             fifo_full_r, overflow_r;
  logic             fifo_empty_s, fifo_full_s, wr_en_s, pop_s;

  // FSM state and registered outputs
  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] tmr_r, tmr_nx_s;
  logic [WC_W-1:0]  remaining_r, remaining_nx_s;
  logic             cs_n_r, cs_n_nx_s, busy_r, busy_nx_s, done_r, done_nx_s;
  logic             tx_dv_r, tx_dv_nx_s, rx_dv_r, rx_dv_nx_s;
  logic [15:0]      tx_word_r, tx_word_nx_s, rx_word_r, rx_word_nx_s;

  assign fifo_empty_s = (fifo_cnt_r == (PTR_W+1)'(0));
  assign fifo_full_s  = (fifo_cnt_r == (PTR_W+1)'(FIFO_DEPTH));
  // A write while full is dropped even if a pop happens in the same cycle.
  assign wr_en_s      = i_Data_DV && !fifo_full_s;

  // FIFO occupancy after this cycle's write/pop
  always_comb begin
    fifo_cnt_nx_s = fifo_cnt_r;
    case ({wr_en_s, pop_s})
      2'b10:   fifo_cnt_nx_s = fifo_cnt_r + (PTR_W+1)'(1);
      2'b01:   fifo_cnt_nx_s = fifo_cnt_r - (PTR_W+1)'(1);
      default: fifo_cnt_nx_s = fifo_cnt_r;
    endcase
  end

  // FIFO data array; contents need no reset because occupancy gates reads
  always_ff @(posedge i_Clk) begin
    if (wr_en_s) begin
      fifo_mem_r[wr_ptr_r] <= i_Data;
    end
  end

  // FIFO pointers, occupancy, full flag and overflow pulse
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      fifo_cnt_r  <= (PTR_W+1)'(0);
      fifo_full_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      fifo_cnt_r  <= fifo_cnt_nx_s;
      fifo_full_r <= (fifo_cnt_nx_s == (PTR_W+1)'(FIFO_DEPTH));
      overflow_r  <= i_Data_DV && fifo_full_s;
    end
  end

  // Transaction FSM: next state, timers and next values of registered outputs
  always_comb begin
    state_nx_s     = state_r;
    tmr_nx_s       = tmr_r;
    remaining_nx_s = remaining_r;
    cs_n_nx_s      = cs_n_r;
    busy_nx_s      = busy_r;
    done_nx_s      = 1'b0;
    tx_dv_nx_s     = 1'b0;
    tx_word_nx_s   = tx_word_r;
    rx_dv_nx_s     = 1'b0;
    rx_word_nx_s   = rx_word_r;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_Start && (i_Word_Count != WC_W'(0))) begin
          remaining_nx_s = i_Word_Count;
          cs_n_nx_s      = 1'b0;
          busy_nx_s      = 1'b1;
          // The start cycle itself counts toward setup; LOAD adds one more.
          tmr_nx_s       = CNT_W'(1);
          state_nx_s     = (CS_SETUP_CLKS == 32'sd1) ? ST_LOAD : ST_SETUP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_r >= CNT_W'(CS_SETUP_CLKS - 1)) begin
          state_nx_s = ST_LOAD;
        end else begin
          tmr_nx_s = tmr_r + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (i_TX_Ready && !fifo_empty_s) begin
          tx_dv_nx_s   = 1'b1;
          tx_word_nx_s = fifo_mem_r[rd_ptr_r];
          pop_s        = 1'b1;
          state_nx_s   = ST_WAIT_RX;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_WAIT_RX: begin
        if (i_RX_DV) begin
          rx_word_nx_s   = i_RX_Word;
          rx_dv_nx_s     = 1'b1;
          remaining_nx_s = remaining_r - WC_W'(1);
          if (remaining_r == WC_W'(1)) begin
            tmr_nx_s   = CNT_W'(1);
            state_nx_s = ST_HOLD;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_WAIT_RX;
        end
      end
      ST_HOLD: begin
        if (tmr_r >= CNT_W'(CS_HOLD_CLKS)) begin
          cs_n_nx_s  = 1'b1;
          done_nx_s  = 1'b1;
          tmr_nx_s   = CNT_W'(1);
          state_nx_s = ST_GAP;
        end else begin
          tmr_nx_s = tmr_r + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_r >= CNT_W'(CS_IDLE_CLKS)) begin
          busy_nx_s  = 1'b0;
          state_nx_s = ST_IDLE;
        end else begin
          tmr_nx_s = tmr_r + CNT_W'(1);
        end
      end
      default: begin
        cs_n_nx_s  = 1'b1;
        busy_nx_s  = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r     <= ST_IDLE;
      tmr_r       <= CNT_W'(0);
      remaining_r <= WC_W'(0);
      cs_n_r      <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      tx_dv_r     <= 1'b0;
      tx_word_r   <= 16'h0000;
      rx_dv_r     <= 1'b0;
      rx_word_r   <= 16'h0000;
    end else begin
      state_r     <= state_nx_s;
      tmr_r       <= tmr_nx_s;
      remaining_r <= remaining_nx_s;
      cs_n_r      <= cs_n_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      tx_dv_r     <= tx_dv_nx_s;
      tx_word_r   <= tx_word_nx_s;
      rx_dv_r     <= rx_dv_nx_s;
      rx_word_r   <= rx_word_nx_s;
    end
  end

  assign o_SPI_CS_n  = cs_n_r;
  assign o_Busy      = busy_r;
  assign o_Done      = done_r;
  assign o_TX_DV     = tx_dv_r;
  assign o_TX_Word   = tx_word_r;
  assign o_RX_DV     = rx_dv_r;
  assign o_RX_Word   = rx_word_r;
  assign o_FIFO_Full = fifo_full_r;
  assign o_Overflow  = overflow_r;

endmodule
